// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and PS/2 line bundle for the host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_start;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic busy;
  logic done;
  logic ack_err;
  logic timeout;
  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
  );
  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter driving open-drain pull-low enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int RTS_CYCLES = 65,
  parameter int TIMEOUT_CYCLES = 1105000
) (
  input logic pclk,
  input logic rst,
  ps2_host_tx_if.slave bus
);
  localparam int PW = $clog2((INHIBIT_CYCLES > RTS_CYCLES ? INHIBIT_CYCLES : RTS_CYCLES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK_WAIT, RELEASE} state_t;
  state_t state, state_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0] bit_idx, bit_idx_n;
  logic [9:0] frame, frame_n;
  logic [1:0] clk_sync, data_sync;
  logic clk_prev, clk_s, data_s, fall, tout;
  logic clk_oe, clk_oe_n, data_oe, data_oe_n, busy, busy_n;
  logic done, done_n, ack_err, ack_err_n, timeout, timeout_n;
  assign clk_s = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall = clk_prev & ~clk_s;
  assign tout = (state == SEND || state == ACK_WAIT || state == RELEASE) &&
                tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign bus.ps2_clk_oe = clk_oe;
  assign bus.ps2_data_oe = data_oe;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.ack_err = ack_err;
  assign bus.timeout = timeout;
  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_prev <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      bit_idx <= '0;
      frame <= '0;
      clk_oe <= 1'b0;
      data_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ack_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], bus.ps2_clk_in};
      data_sync <= {data_sync[0], bus.ps2_data_in};
      clk_prev <= clk_s;
      state <= state_n;
      cnt <= cnt_n;
      tcnt <= tcnt_n;
      bit_idx <= bit_idx_n;
      frame <= frame_n;
      clk_oe <= clk_oe_n;
      data_oe <= data_oe_n;
      busy <= busy_n;
      done <= done_n;
      ack_err <= ack_err_n;
      timeout <= timeout_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tcnt_n = tcnt;
    bit_idx_n = bit_idx;
    frame_n = frame;
    clk_oe_n = clk_oe;
    data_oe_n = data_oe;
    done_n = 1'b0;
    ack_err_n = ack_err;
    timeout_n = timeout;
    case (state)
      IDLE: begin
        clk_oe_n = 1'b0;
        data_oe_n = 1'b0;
        cnt_n = '0;
        if (bus.tx_start) begin
          state_n = INHIBIT;
          frame_n = {1'b1, ~^bus.tx_data, bus.tx_data};
          ack_err_n = 1'b0;
          timeout_n = 1'b0;
          clk_oe_n = 1'b1;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == PW'(INHIBIT_CYCLES - 1)) begin
          data_oe_n = 1'b1;
          state_n = RTS;
          cnt_n = '0;
        end
      end
      RTS: begin
        cnt_n = cnt + 1'b1;
        if (cnt == PW'(RTS_CYCLES - 1)) begin
          clk_oe_n = 1'b0;
          state_n = SEND;
          bit_idx_n = '0;
          tcnt_n = '0;
        end
      end
      SEND: begin
        tcnt_n = tcnt + 1'b1;
        // the stop bit (frame[9]) releases data, leaving the line free for the ack
        if (fall) begin
          data_oe_n = ~frame[bit_idx];
          bit_idx_n = bit_idx + 4'd1;
          state_n = bit_idx == 4'd9 ? ACK_WAIT : SEND;
        end
      end
      ACK_WAIT: begin
        tcnt_n = tcnt + 1'b1;
        if (fall) begin
          ack_err_n = data_s;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        tcnt_n = tcnt + 1'b1;
        if (clk_s && data_s) begin
          done_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // timeout overrides any same-cycle edge handling
    if (tout) begin
      clk_oe_n = 1'b0;
      data_oe_n = 1'b0;
      timeout_n = 1'b1;
      done_n = 1'b1;
      state_n = IDLE;
    end
    busy_n = state_n != IDLE;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model with scoreboarded frames for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int RTS = 4;
  localparam int TMO = 2000;
  typedef struct {
    logic [7:0] data;
    logic ack;
    logic par;
    logic ack_err;
  } vec_t;
  typedef struct {
    logic [7:0] data;
    logic par;
    logic ack_err;
    logic tmo;
  } exp_t;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic [10:0] seen;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sbq[$];
  vec_t vecs[5];
  ps2_host_tx_if bus();
  assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 pclk = ~pclk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge pclk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_clk_oe"}, 32'(bus.ps2_clk_oe), 0);
    chk({tag, "_data_oe"}, 32'(bus.ps2_data_oe), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_ack_err"}, 32'(bus.ack_err), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 0);
  endtask
  task automatic start_tx(input logic [7:0] d);
    int c;
    bus.tx_data = d;
    bus.tx_start = 1'b1;
    tick;
    bus.tx_start = 1'b0;
    chk("accept_busy", 32'(bus.busy), 1);
    chk("accept_clk_oe", 32'(bus.ps2_clk_oe), 1);
    chk("done_width", 32'(bus.done), 0);
    c = 0;
    while (!bus.ps2_data_oe && c < 100) begin
      tick;
      c++;
    end
    chk("data_oe_delay", c, INH);
    while (bus.ps2_clk_oe && c < 200) begin
      tick;
      c++;
    end
    chk("clk_release_delay", c, INH + RTS);
  endtask
  task automatic device_frame(input logic ack, input logic [9:0] bits);
    logic prev;
    logic e;
    int lat;
    seen[0] = bus.ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      repeat (10) tick;
      if (i == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      prev = bus.ps2_data_oe;
      lat = 0;
      for (int c = 1; c <= 6; c++) begin
        tick;
        if (lat == 0 && bus.ps2_data_oe != prev) lat = c;
      end
      if (i <= 10) begin
        e = ~bits[i-1];
        chk($sformatf("bit%0d_oe", i - 1), 32'(bus.ps2_data_oe), 32'(e));
        if (e != prev) chk($sformatf("bit%0d_latency", i - 1), lat, 3);
      end
      repeat (14) tick;
      dev_clk = 1'b1;
      if (i <= 10) seen[i] = bus.ps2_data_in;
      dev_data = 1'b1;
      if (i < 11) repeat (10) tick;
    end
  endtask
  task automatic wait_done(input int bound, output int c);
    c = 0;
    while (!bus.done && c < bound) begin
      tick;
      c++;
    end
    if (!bus.done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: no done within %0d cycles", bound);
    end
  endtask
  task automatic check_result;
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: done with no expected frame queued");
      return;
    end
    e = sbq.pop_front();
    chk("done", 32'(bus.done), 1);
    chk("ack_err", 32'(bus.ack_err), 32'(e.ack_err));
    chk("timeout", 32'(bus.timeout), 32'(e.tmo));
    chk("busy_at_done", 32'(bus.busy), 0);
    chk("clk_oe_at_done", 32'(bus.ps2_clk_oe), 0);
    chk("data_oe_at_done", 32'(bus.ps2_data_oe), 0);
    if (!e.tmo) begin
      chk("start_bit", 32'(seen[0]), 0);
      chk("data_byte", 32'(seen[8:1]), 32'(e.data));
      chk("parity", 32'(seen[9]), 32'(e.par));
      chk("stop_bit", 32'(seen[10]), 1);
    end
  endtask
  task automatic run_frame(input vec_t v);
    int c;
    sbq.push_back(exp_t'{v.data, v.par, v.ack_err, 1'b0});
    start_tx(v.data);
    device_frame(v.ack, {1'b1, v.par, v.data});
    wait_done(200, c);
    check_result();
  endtask
  initial begin
    int c;
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    vecs = '{
      vec_t'{8'hF4, 1'b1, 1'b0, 1'b0},
      vec_t'{8'hFF, 1'b0, 1'b1, 1'b1},
      vec_t'{8'h00, 1'b1, 1'b1, 1'b0},
      vec_t'{8'hA5, 1'b1, 1'b1, 1'b0},
      vec_t'{8'h01, 1'b0, 1'b0, 1'b1}
    };
    repeat (3) tick;
    chk_idle("reset");
    rst = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
      repeat (5) tick;
    end
    fork
      run_frame(vec_t'{8'hF4, 1'b1, 1'b0, 1'b0});
      begin
        repeat (150) tick;
        bus.tx_data = 8'h00;
        bus.tx_start = 1'b1;
        tick;
        bus.tx_start = 1'b0;
      end
    join
    run_frame(vec_t'{8'h00, 1'b1, 1'b1, 1'b0});
    repeat (5) tick;
    sbq.push_back(exp_t'{8'h5A, 1'b0, 1'b0, 1'b1});
    start_tx(8'h5A);
    wait_done(TMO + 100, c);
    chk("timeout_delay", c, TMO);
    check_result();
    tick;
    chk("timeout_done_width", 32'(bus.done), 0);
    repeat (5) tick;
    start_tx(8'hF4);
    for (int i = 0; i < 2; i++) begin
      repeat (10) tick;
      dev_clk = 1'b0;
      repeat (20) tick;
      dev_clk = 1'b1;
      repeat (10) tick;
    end
    chk("pre_reset_data_oe", 32'(bus.ps2_data_oe), 1);
    rst = 1'b1;
    tick;
    chk_idle("mid_reset");
    rst = 1'b0;
    repeat (3) tick;
    run_frame(vec_t'{8'hF4, 1'b1, 1'b0, 1'b0});
    repeat (3) tick;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d frames left, 0 expected", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
